// File: rtl/acc_controller.sv
// acc_controller: sequences accumulator writes over K-passes, then drains saturated rows with backpressure
module acc_controller #(
    parameter int ADDR_WIDTH = 6,
    parameter int PASS_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   num_rows,
    input  logic [PASS_WIDTH-1:0] num_passes,
    input  logic                  psum_valid,
    output logic                  acc_wea,
    output logic                  acc_en,
    output logic [ADDR_WIDTH-1:0] acc_addra,
    output logic                  acc_enb,
    output logic [ADDR_WIDTH-1:0] acc_addrb,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  cmd_err
);
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;
    localparam logic [ADDR_WIDTH:0]   ROW_ONE  = 1;
    localparam logic [PASS_WIDTH-1:0] PASS_ONE = 1;
    state_t                state, next_state;
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH:0]   rows, row_cnt, rd_cnt, hs_cnt;
    logic [PASS_WIDTH-1:0] passes, pass_cnt;
    logic                  accept, last_row, last_write, handshake, last_hs;
    assign accept     = state == IDLE && start && num_rows != '0 && num_passes != '0;
    assign last_row   = row_cnt == rows - ROW_ONE;
    assign acc_wea    = state == ACCUM && psum_valid;
    assign last_write = acc_wea && last_row && pass_cnt == passes - PASS_ONE;
    assign acc_en     = state == ACCUM && pass_cnt != '0;
    assign acc_addra  = acc_wea ? base + row_cnt[ADDR_WIDTH-1:0] : '0;
    // A new read is issued only when the output register is empty or being emptied this cycle
    assign acc_enb    = state == DRAIN && rd_cnt < rows && (!out_valid || out_ready);
    assign acc_addrb  = acc_enb ? base + rd_cnt[ADDR_WIDTH-1:0] : '0;
    assign handshake  = out_valid && out_ready;
    assign last_hs    = handshake && hs_cnt == rows - ROW_ONE;
    assign busy       = state != IDLE;
    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end
    // Next-state decode
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = accept ? ACCUM : IDLE;
            ACCUM:   next_state = last_write ? DRAIN : ACCUM;
            DRAIN:   next_state = last_hs ? IDLE : DRAIN;
            default: next_state = IDLE;
        endcase
    end
    // Command latch, row/pass/read/handshake counters and registered status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base      <= '0;
            rows      <= '0;
            passes    <= '0;
            row_cnt   <= '0;
            pass_cnt  <= '0;
            rd_cnt    <= '0;
            hs_cnt    <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            cmd_err   <= state == IDLE && start && !accept;
            done      <= last_hs;
            out_valid <= acc_enb ? 1'b1 : (handshake ? 1'b0 : out_valid);
            if (accept) begin
                base     <= base_addr;
                rows     <= num_rows;
                passes   <= num_passes;
                row_cnt  <= '0;
                pass_cnt <= '0;
                rd_cnt   <= '0;
                hs_cnt   <= '0;
            end
            if (acc_wea) begin
                row_cnt <= last_row ? '0 : row_cnt + ROW_ONE;
                if (last_row) pass_cnt <= pass_cnt + PASS_ONE;
            end
            if (acc_enb) rd_cnt <= rd_cnt + ROW_ONE;
            if (handshake) hs_cnt <= hs_cnt + ROW_ONE;
        end
    end
endmodule

// File: doc/acc_controller.md
ACC_CONTROLLER -- requirements
Module: acc_controller

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, meaning accumulator address width (64 entries).
REQ-002 SHALL have parameter PASS_WIDTH, default 8, meaning width of the partial-sum pass counter.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle command strobe; sampled only in IDLE.
REQ-006 SHALL have port base_addr  input  ADDR_WIDTH  first accumulator row of the tile.
REQ-007 SHALL have port num_rows  input  ADDR_WIDTH+1  rows per tile, legal 1..2^ADDR_WIDTH.
REQ-008 SHALL have port num_passes  input  PASS_WIDTH  number of K-passes to accumulate, legal >=1.
REQ-009 SHALL have port psum_valid  input  1  systolic array presents one partial-sum row this cycle.
REQ-010 SHALL have port acc_wea  output  1  accumulator write enable.
REQ-011 SHALL have port acc_en  output  1  accumulate (1) or overwrite (0) select.
REQ-012 SHALL have port acc_addra  output  ADDR_WIDTH  accumulator write address.
REQ-013 SHALL have port acc_enb  output  1  accumulator read enable.
REQ-014 SHALL have port acc_addrb  output  ADDR_WIDTH  accumulator read address.
REQ-015 SHALL have port out_valid  output  1  saturated accumulator row valid on accumulator doutb.
REQ-016 SHALL have port out_ready  input  1  downstream accepts row when out_valid&&out_ready.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-018 SHALL have port done  output  1  one-cycle pulse after the last row handshake.
REQ-019 SHALL have port cmd_err  output  1  one-cycle pulse on illegal start.

Function
REQ-020 SHALL implement states IDLE, ACCUM, DRAIN; IDLE->ACCUM on legal start; ACCUM->DRAIN after last row of last pass written; DRAIN->IDLE on last output handshake.
REQ-021 SHALL latch base_addr, num_rows, num_passes on accepted start; inputs ignored afterwards.
REQ-022 SHALL treat start with num_rows==0 or num_passes==0 as illegal: pulse cmd_err next cycle, remain IDLE.
REQ-023 SHALL ignore start while busy (no cmd_err, no state change).
REQ-024 SHALL in ACCUM drive acc_wea=psum_valid combinationally, acc_addra=(base+row_cnt) mod 2^ADDR_WIDTH, acc_en=(pass_cnt!=0).
REQ-025 SHALL increment row_cnt on each psum_valid in ACCUM; at row_cnt==num_rows-1 wrap row_cnt to 0 and increment pass_cnt.
REQ-026 SHALL enter DRAIN the cycle after the write with row_cnt==num_rows-1 and pass_cnt==num_passes-1.
REQ-027 SHALL hold acc_wea=0 outside ACCUM; psum_valid in IDLE or DRAIN is ignored.
REQ-028 SHALL in DRAIN assert acc_enb=1 iff rd_cnt<num_rows and (!out_valid or out_ready); acc_addrb=(base+rd_cnt) mod 2^ADDR_WIDTH; rd_cnt increments when acc_enb=1.
REQ-029 SHALL register out_valid: set the cycle after acc_enb=1; cleared after handshake with no new read; held while out_valid&&!out_ready (accumulator output holds with enb low).
REQ-030 SHALL sustain one row per cycle when out_ready is held high; read latency acc_enb->out_valid is exactly 1 cycle.
REQ-031 SHALL count handshakes; on handshake number num_rows pulse done in the following cycle and return to IDLE with out_valid=0.
REQ-032 SHALL allow a new start in the cycle done is high (controller already IDLE).
REQ-033 SHALL keep acc_addra/acc_addrb at 0 when their enable is low.

Reset
REQ-034 SHALL on rst_n=0, asynchronously: state=IDLE, all counters 0, acc_wea=acc_en=acc_enb=0, addresses 0, out_valid=busy=done=cmd_err=0.
REQ-035 SHALL abort any in-flight tile on reset mid-operation with no further accumulator accesses until a new start.

Verification
REQ-036 base=0, rows=4, passes=1, psum_valid 4 cycles, out_ready=1 -> wea@addr0..3 acc_en=0; enb addr0..3 back-to-back; out_valid 4 cycles; done 1 cycle after 4th handshake.
REQ-037 rows=2, passes=3 -> pass0 acc_en=0, passes1-2 acc_en=1 on addr base,base+1; DRAIN only after 6th write.
REQ-038 base=62, rows=4 -> write/read addresses 62,63,0,1.
REQ-039 DRAIN with out_ready toggling 1,0,0,1,1 -> acc_enb never asserted while out_valid&&!out_ready; no row lost or duplicated; row order preserved.
REQ-040 start with num_passes=0 -> cmd_err pulse, busy stays 0; start during ACCUM -> ignored.
REQ-041 rst_n low during DRAIN after 2 rows -> all outputs 0 immediately; after release, psum_valid ignored until next start.
